// File: rtl/rambus_arbiter.sv
// rambus_arbiter: shares the single SRAM wishbone master port between the core
// data-memory port (16-bit) and the host wishbone slave port (32-bit).
// One transaction at a time: grant, bus cycle, wait for ack, return data, release.
// Round-robin between requesters when both ask in the same IDLE cycle.
// Optional feature macro: RAMBUS_TIMEOUT_EN -- aborts a bus cycle that has had no
// ack for TIMEOUT_CYCLES cycles, returns a DEAD pattern and sets a sticky o_err.
module rambus_arbiter #(
   parameter int ADDR_W         = 10,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic              clk,
   input  logic              reset,
   // core data-memory port
   input  logic              core_req,
   input  logic              core_we,
   input  logic [ADDR_W-1:0] core_addr,
   input  logic [15:0]       core_wdata,
   output logic [15:0]       core_rdata,
   output logic              core_done,
   // host wishbone slave port
   input  logic              i_wb_cyc,
   input  logic              i_wb_stb,
   input  logic              i_wb_we,
   input  logic [31:0]       i_wb_addr,
   input  logic [31:0]       i_wb_data,
   output logic              o_wb_ack,
   output logic [31:0]       o_wb_data,
   // SRAM wishbone master port
   output logic              rambus_wb_clk_o,
   output logic              rambus_wb_rst_o,
   output logic              rambus_wb_cyc_o,
   output logic              rambus_wb_stb_o,
   output logic              rambus_wb_we_o,
   output logic [3:0]        rambus_wb_sel_o,
   output logic [ADDR_W-1:0] rambus_wb_addr_o,
   output logic [31:0]       rambus_wb_dat_o,
   input  logic              rambus_wb_ack_i,
   input  logic [31:0]       rambus_wb_dat_i,
   // status
   output logic              o_busy,
   output logic              o_err
);

   typedef enum logic [1:0] {S_IDLE, S_CORE_BUS, S_HOST_BUS, S_RELEASE} state_t;

   // The wait counter width is 8..16 bits, so the limit must fit in 16 bits.
   if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
      $error("rambus_arbiter: TIMEOUT_CYCLES must be in 1..65535");
   end

   state_t            state_q, state_d;
   logic              last_host_q, last_host_d;   // 1 = host held the last grant
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              we_q, we_d;
   logic [31:0]       dat_q, dat_d;
   logic [3:0]        sel_q, sel_d;
   logic              core_done_q, core_done_d;
   logic [15:0]       core_rdata_q, core_rdata_d;
   logic              wb_ack_q, wb_ack_d;
   logic [31:0]       wb_data_q, wb_data_d;

   logic              host_req, grant_core, grant_host, in_bus, timeout;

   // Only the word-address bits of the host byte address reach the SRAM.
   logic              unused_wb_addr;
   assign unused_wb_addr = ^{i_wb_addr[31:ADDR_W+2], i_wb_addr[1:0]};

   assign host_req   = i_wb_cyc & i_wb_stb;
   // With both asking, the side that did not win last time gets the bus.
   assign grant_core = core_req & (~host_req | last_host_q);
   assign grant_host = host_req & (~core_req | ~last_host_q);
   assign in_bus     = (state_q == S_CORE_BUS) || (state_q == S_HOST_BUS);

`ifdef RAMBUS_TIMEOUT_EN
   localparam int CLOG_T = $clog2(TIMEOUT_CYCLES + 1);
   localparam int CNT_W  = (CLOG_T < 8) ? 8 : ((CLOG_T > 16) ? 16 : CLOG_T);

   logic [CNT_W-1:0] wait_q;
   logic             err_q;

   // Last waiting cycle before the limit: the next edge terminates the cycle.
   assign timeout = in_bus && (wait_q == CNT_W'(TIMEOUT_CYCLES - 1));

   // Wait counter: held at zero outside the bus states, so each entry starts fresh.
   always_ff @(posedge clk) begin
      if (reset || !in_bus) wait_q <= '0;
      else                  wait_q <= wait_q + 1'b1;
   end

   // Sticky error: set when a bus cycle is terminated by the timeout.
   always_ff @(posedge clk) begin
      if (reset)
         err_q <= 1'b0;
      else if (timeout && !rambus_wb_ack_i &&
               !(state_q == S_HOST_BUS && !i_wb_cyc))
         err_q <= 1'b1;
   end

   assign o_err = err_q;
`else
   assign timeout = 1'b0;
   assign o_err   = 1'b0;
`endif

   // Next-state, latching and response logic.
   always_comb begin
      state_d      = state_q;
      last_host_d  = last_host_q;
      addr_d       = addr_q;
      we_d         = we_q;
      dat_d        = dat_q;
      sel_d        = sel_q;
      core_done_d  = 1'b0;
      core_rdata_d = core_rdata_q;
      wb_ack_d     = 1'b0;
      wb_data_d    = wb_data_q;
      case (state_q)
         S_IDLE: begin
            if (grant_core) begin
               addr_d      = core_addr;
               we_d        = core_we;
               dat_d       = {16'h0, core_wdata};
               sel_d       = 4'b0011;
               last_host_d = 1'b0;
               state_d     = S_CORE_BUS;
            end else if (grant_host) begin
               addr_d      = i_wb_addr[ADDR_W+1:2];
               we_d        = i_wb_we;
               dat_d       = i_wb_data;
               sel_d       = 4'b1111;
               last_host_d = 1'b1;
               state_d     = S_HOST_BUS;
            end
         end
         S_CORE_BUS: begin
            // The core keeps no say once granted: the cycle always completes.
            if (rambus_wb_ack_i) begin
               core_done_d  = 1'b1;
               core_rdata_d = rambus_wb_dat_i[15:0];
               state_d      = S_RELEASE;
            end else if (timeout) begin
               core_done_d  = 1'b1;
               core_rdata_d = 16'hDEAD;
               state_d      = S_RELEASE;
            end
         end
         S_HOST_BUS: begin
            // A host abort wins over an ack arriving on the same edge.
            if (!i_wb_cyc) begin
               state_d = S_RELEASE;
            end else if (rambus_wb_ack_i) begin
               wb_ack_d  = 1'b1;
               wb_data_d = rambus_wb_dat_i;
               state_d   = S_RELEASE;
            end else if (timeout) begin
               wb_ack_d  = 1'b1;
               wb_data_d = 32'hDEADDEAD;
               state_d   = S_RELEASE;
            end
         end
         S_RELEASE: begin
            // One dead cycle so the host can drop stb before the next grant.
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and latched transaction registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= S_IDLE;
         last_host_q  <= 1'b1;
         addr_q       <= '0;
         we_q         <= 1'b0;
         dat_q        <= '0;
         sel_q        <= '0;
         core_done_q  <= 1'b0;
         core_rdata_q <= '0;
         wb_ack_q     <= 1'b0;
         wb_data_q    <= '0;
      end else begin
         state_q      <= state_d;
         last_host_q  <= last_host_d;
         addr_q       <= addr_d;
         we_q         <= we_d;
         dat_q        <= dat_d;
         sel_q        <= sel_d;
         core_done_q  <= core_done_d;
         core_rdata_q <= core_rdata_d;
         wb_ack_q     <= wb_ack_d;
         wb_data_q    <= wb_data_d;
      end
   end

   assign rambus_wb_clk_o  = clk;
   assign rambus_wb_rst_o  = reset;
   assign rambus_wb_cyc_o  = in_bus;
   assign rambus_wb_stb_o  = in_bus;
   assign rambus_wb_we_o   = in_bus & we_q;
   assign rambus_wb_sel_o  = sel_q;
   assign rambus_wb_addr_o = addr_q;
   assign rambus_wb_dat_o  = dat_q;
   assign core_done        = core_done_q;
   assign core_rdata       = core_rdata_q;
   assign o_wb_ack         = wb_ack_q;
   assign o_wb_data        = wb_data_q;
   assign o_busy           = (state_q != S_IDLE);

endmodule

// File: tb/tb_rambus_arbiter.sv
// Bench for rambus_arbiter: directed scenarios plus a randomized run of two
// independent requesters against an SRAM responder and transaction scoreboards.
module tb_rambus_arbiter;
   localparam int ADDR_W = 10;

   logic              clk = 1'b0;
   logic              reset;
   logic              core_req, core_we;
   logic [ADDR_W-1:0] core_addr;
   logic [15:0]       core_wdata, core_rdata;
   logic              core_done;
   logic              i_wb_cyc, i_wb_stb, i_wb_we;
   logic [31:0]       i_wb_addr, i_wb_data, o_wb_data;
   logic              o_wb_ack;
   logic              rambus_wb_clk_o, rambus_wb_rst_o, rambus_wb_cyc_o, rambus_wb_stb_o, rambus_wb_we_o;
   logic [3:0]        rambus_wb_sel_o;
   logic [ADDR_W-1:0] rambus_wb_addr_o;
   logic [31:0]       rambus_wb_dat_o, rambus_wb_dat_i;
   logic              rambus_wb_ack_i;
   logic              o_busy, o_err;

   int errors = 0;
   int checks = 0;

   // SRAM responder state
   logic [31:0] mem [0:1023];
   int          ack_delay = 1;
   bit          sram_en   = 1'b1;
   bit          ack_noise = 1'b0;
   int          wcnt      = 0;

   always #5 clk = ~clk;

   rambus_arbiter #(.ADDR_W(ADDR_W), .TIMEOUT_CYCLES(8)) dut (
      .clk(clk), .reset(reset),
      .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
      .core_wdata(core_wdata), .core_rdata(core_rdata), .core_done(core_done),
      .i_wb_cyc(i_wb_cyc), .i_wb_stb(i_wb_stb), .i_wb_we(i_wb_we),
      .i_wb_addr(i_wb_addr), .i_wb_data(i_wb_data), .o_wb_ack(o_wb_ack), .o_wb_data(o_wb_data),
      .rambus_wb_clk_o(rambus_wb_clk_o), .rambus_wb_rst_o(rambus_wb_rst_o),
      .rambus_wb_cyc_o(rambus_wb_cyc_o), .rambus_wb_stb_o(rambus_wb_stb_o),
      .rambus_wb_we_o(rambus_wb_we_o), .rambus_wb_sel_o(rambus_wb_sel_o),
      .rambus_wb_addr_o(rambus_wb_addr_o), .rambus_wb_dat_o(rambus_wb_dat_o),
      .rambus_wb_ack_i(rambus_wb_ack_i), .rambus_wb_dat_i(rambus_wb_dat_i),
      .o_busy(o_busy), .o_err(o_err)
   );

   // Advance one clock; outputs are then stable. The SRAM acks the
   // ack_delay-th cycle of an active bus cycle, writes on that ack.
   task automatic step();
      @(posedge clk);
      #1;
      if (rambus_wb_cyc_o && rambus_wb_stb_o) begin
         wcnt++;
         if (sram_en && wcnt >= ack_delay) begin
            rambus_wb_ack_i = 1'b1;
            rambus_wb_dat_i = mem[rambus_wb_addr_o];
            if (rambus_wb_we_o) mem[rambus_wb_addr_o] = rambus_wb_dat_o;
         end else begin
            rambus_wb_ack_i = 1'b0;
            rambus_wb_dat_i = $urandom;
         end
      end else begin
         wcnt            = 0;
         rambus_wb_ack_i = ack_noise;
         rambus_wb_dat_i = $urandom;
      end
   endtask

   task automatic clear_inputs();
      core_req = 0; core_we = 0; core_addr = '0; core_wdata = '0;
      i_wb_cyc = 0; i_wb_stb = 0; i_wb_we = 0; i_wb_addr = '0; i_wb_data = '0;
   endtask

   task automatic do_reset();
      clear_inputs();
      reset = 1'b1;
      step(); step();
      reset = 1'b0;
   endtask

   task automatic go_idle();
      for (int i = 0; i < 50 && o_busy; i++) step();
      checks++;
      if (o_busy !== 1'b0) begin errors++; $display("FAIL go_idle: busy=%b want 0", o_busy); end
   endtask

   task automatic test_reset();
      clear_inputs();
      rambus_wb_ack_i = 0; rambus_wb_dat_i = '0;
      reset = 1'b1;
      step(); step();
      reset = 1'b0;
      step();
      checks++;
      if ({rambus_wb_cyc_o, rambus_wb_stb_o, rambus_wb_we_o, rambus_wb_sel_o, rambus_wb_addr_o,
           rambus_wb_dat_o, core_done, core_rdata, o_wb_ack, o_wb_data, o_busy, o_err} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: cyc=%b sel=%h addr=%h dat=%h done=%b rd=%h ack=%b wd=%h busy=%b err=%b want all 0",
                  rambus_wb_cyc_o, rambus_wb_sel_o, rambus_wb_addr_o, rambus_wb_dat_o, core_done,
                  core_rdata, o_wb_ack, o_wb_data, o_busy, o_err);
      end
      // stray ack while idle must be ignored
      ack_noise = 1'b1; step(); ack_noise = 1'b0; step();
      checks++;
      if ({core_done, o_wb_ack, o_busy, rambus_wb_cyc_o} !== 4'b0) begin
         errors++;
         $display("FAIL idle_ack_ignored: done=%b ack=%b busy=%b cyc=%b want 0", core_done, o_wb_ack, o_busy, rambus_wb_cyc_o);
      end
   endtask

   task automatic test_core_read();
      int lat = -1, pulses = 0, t = 0;
      bit seen = 0;
      mem[5] = 32'h1234ABCD;
      ack_delay = 1;
      core_req = 1; core_we = 0; core_addr = 10'h005;
      for (int i = 1; i <= 20 && pulses == 0; i++) begin
         step();
         if (rambus_wb_cyc_o && !seen) begin
            seen = 1;
            checks++;
            if (rambus_wb_sel_o !== 4'b0011 || rambus_wb_addr_o !== 10'h005 || rambus_wb_we_o !== 1'b0) begin
               errors++;
               $display("FAIL core_read_bus: sel=%b addr=%h we=%b want 0011/005/0", rambus_wb_sel_o, rambus_wb_addr_o, rambus_wb_we_o);
            end
         end
         if (core_done) begin pulses++; lat = i; core_req = 0;
            checks++;
            if (core_rdata !== 16'hABCD) begin errors++; $display("FAIL core_read_data: got %h want abcd", core_rdata); end
         end
      end
      checks++;
      if (lat != 2) begin errors++; $display("FAIL core_read_latency: got %0d want 2", lat); end
      for (int i = 0; i < 4; i++) begin step(); if (core_done) t++; end
      checks++;
      if (t != 0 || core_rdata !== 16'hABCD) begin
         errors++; $display("FAIL core_done_single: extra=%0d rdata=%h want 0/abcd", t, core_rdata);
      end
   endtask

   task automatic test_host_write();
      int acks = 0;
      bit seen = 0;
      ack_delay = 2;
      i_wb_cyc = 1; i_wb_stb = 1; i_wb_we = 1; i_wb_addr = 32'h10; i_wb_data = 32'hCAFEF00D;
      for (int i = 0; i < 30; i++) begin
         step();
         if (rambus_wb_cyc_o && !seen) begin
            seen = 1;
            checks++;
            if (rambus_wb_addr_o !== 10'h004 || rambus_wb_sel_o !== 4'b1111 || rambus_wb_we_o !== 1'b1 ||
                rambus_wb_dat_o !== 32'hCAFEF00D) begin
               errors++;
               $display("FAIL host_write_bus: addr=%h sel=%b we=%b dat=%h want 004/1111/1/cafef00d",
                        rambus_wb_addr_o, rambus_wb_sel_o, rambus_wb_we_o, rambus_wb_dat_o);
            end
         end
         if (o_wb_ack) begin acks++; i_wb_cyc = 0; i_wb_stb = 0; end
      end
      checks++;
      if (acks != 1 || mem[4] !== 32'hCAFEF00D) begin
         errors++; $display("FAIL host_write_ack: acks=%0d mem=%h want 1/cafef00d", acks, mem[4]);
      end
      ack_delay = 1;
   endtask

   task automatic test_round_robin();
      int grants = 0, low_run = 0;
      bit exp_host = 0, got_host, prev_cyc = 0, reraise = 0, stop = 0;
      do_reset();
      ack_delay = 1;
      core_req = 1; core_we = 0; core_addr = 10'h011;
      i_wb_cyc = 1; i_wb_stb = 1; i_wb_we = 0; i_wb_addr = 32'h80;
      for (int i = 0; i < 40; i++) begin
         step();
         if (rambus_wb_cyc_o && !prev_cyc) begin
            got_host = (rambus_wb_sel_o == 4'b1111);
            if (grants < 4) begin
               checks++;
               if (got_host !== exp_host) begin errors++; $display("FAIL rr_order: grant %0d host=%b want %b", grants, got_host, exp_host); end
               if (grants > 0) begin
                  checks++;
                  if (low_run != 2) begin errors++; $display("FAIL rr_gap: grant %0d idle cycles=%0d want 2", grants, low_run); end
               end
               grants++;
               exp_host = ~exp_host;
               if (grants == 4) begin stop = 1; core_req = 0; end
            end
         end
         low_run  = rambus_wb_cyc_o ? 0 : low_run + 1;
         prev_cyc = rambus_wb_cyc_o;
         if (o_wb_ack) begin i_wb_cyc = 0; i_wb_stb = 0; reraise = !stop; end
         else if (reraise) begin i_wb_cyc = 1; i_wb_stb = 1; reraise = 0; end
      end
      checks++;
      if (grants != 4) begin errors++; $display("FAIL rr_count: grants=%0d want 4", grants); end
      clear_inputs();
      go_idle();
   endtask

   task automatic test_host_abort();
      int seen = 0, acks = 0;
      sram_en = 0;
      i_wb_cyc = 1; i_wb_stb = 1; i_wb_we = 0; i_wb_addr = 32'h40;
      for (int i = 0; i < 10 && seen < 2; i++) begin step(); if (rambus_wb_cyc_o) seen++; if (o_wb_ack) acks++; end
      i_wb_cyc = 0; i_wb_stb = 0;
      step();
      checks++;
      if (seen != 2 || rambus_wb_cyc_o !== 1'b0 || o_busy !== 1'b1 || o_wb_ack !== 1'b0 || acks != 0) begin
         errors++; $display("FAIL abort_release: seen=%0d cyc=%b busy=%b ack=%b want 2/0/1/0", seen, rambus_wb_cyc_o, o_busy, o_wb_ack);
      end
      step();
      checks++;
      if (o_busy !== 1'b0 || o_wb_ack !== 1'b0) begin errors++; $display("FAIL abort_idle: busy=%b ack=%b want 0/0", o_busy, o_wb_ack); end
      // abort on the same edge the SRAM acks: ack discarded
      sram_en = 1; ack_delay = 2; seen = 0;
      i_wb_cyc = 1; i_wb_stb = 1;
      for (int i = 0; i < 10 && seen < 2; i++) begin step(); if (rambus_wb_cyc_o) seen++; end
      i_wb_cyc = 0; i_wb_stb = 0;
      step();
      checks++;
      if (seen != 2 || o_wb_ack !== 1'b0 || rambus_wb_cyc_o !== 1'b0) begin
         errors++; $display("FAIL abort_with_ack: seen=%0d ack=%b cyc=%b want 2/0/0", seen, o_wb_ack, rambus_wb_cyc_o);
      end
      step();
      go_idle();
      ack_delay = 1;
   endtask

   task automatic test_reset_mid();
      int seen = 0, dones = 0;
      sram_en = 0;
      core_req = 1; core_we = 0; core_addr = 10'h033;
      for (int i = 0; i < 10 && seen < 3; i++) begin step(); if (rambus_wb_cyc_o) seen++; end
      reset = 1;
      step();
      checks++;
      if (seen != 3 || {rambus_wb_cyc_o, rambus_wb_stb_o, core_done, o_busy} !== 4'b0) begin
         errors++; $display("FAIL reset_mid: seen=%0d cyc=%b stb=%b done=%b busy=%b want 3/0/0/0/0",
                            seen, rambus_wb_cyc_o, rambus_wb_stb_o, core_done, o_busy);
      end
      reset = 0; core_req = 0; sram_en = 1;
      for (int i = 0; i < 5; i++) begin step(); if (core_done || o_busy) dones++; end
      checks++;
      if (dones != 0) begin errors++; $display("FAIL reset_mid_lost: activity=%0d want 0", dones); end
   endtask

   task automatic test_timeout();
`ifdef RAMBUS_TIMEOUT_EN
      int bus = 0;
      bit got = 0;
      sram_en = 0;
      core_req = 1; core_we = 0; core_addr = 10'h003;
      for (int i = 0; i < 40 && !got; i++) begin
         step();
         if (rambus_wb_cyc_o) bus++;
         if (core_done) begin got = 1; core_req = 0; end
      end
      checks++;
      if (!got || bus != 8 || core_rdata !== 16'hDEAD || o_err !== 1'b1) begin
         errors++; $display("FAIL timeout_core: done=%b cycles=%0d rdata=%h err=%b want 1/8/dead/1", got, bus, core_rdata, o_err);
      end
      got = 0;
      i_wb_cyc = 1; i_wb_stb = 1; i_wb_we = 0; i_wb_addr = 32'h100;
      for (int i = 0; i < 40 && !got; i++) begin step(); if (o_wb_ack) begin got = 1; i_wb_cyc = 0; i_wb_stb = 0; end end
      checks++;
      if (!got || o_wb_data !== 32'hDEADDEAD) begin errors++; $display("FAIL timeout_host: ack=%b data=%h want 1/deaddead", got, o_wb_data); end
      sram_en = 1;
      go_idle();
      checks++;
      if (o_err !== 1'b1) begin errors++; $display("FAIL err_sticky: err=%b want 1", o_err); end
      do_reset();
      step();
      checks++;
      if (o_err !== 1'b0) begin errors++; $display("FAIL err_reset: err=%b want 0", o_err); end
`else
      int dones = 0;
      sram_en = 0;
      core_req = 1; core_we = 0; core_addr = 10'h003;
      for (int i = 0; i < 30; i++) begin step(); if (core_done) dones++; end
      checks++;
      if (dones != 0 || rambus_wb_cyc_o !== 1'b1 || o_busy !== 1'b1 || o_err !== 1'b0) begin
         errors++; $display("FAIL no_timeout_wait: dones=%0d cyc=%b busy=%b err=%b want 0/1/1/0", dones, rambus_wb_cyc_o, o_busy, o_err);
      end
      sram_en = 1;
      do_reset();
      step();
      checks++;
      if (o_busy !== 1'b0 || rambus_wb_cyc_o !== 1'b0) begin errors++; $display("FAIL no_timeout_recover: busy=%b cyc=%b want 0/0", o_busy, rambus_wb_cyc_o); end
`endif
   endtask

   // Two independent random requesters; core uses words 0..255, host 256..511.
   task automatic test_random();
      logic [15:0] cm [0:255];
      logic [31:0] hm [0:255];
      logic [31:0] v, hb;
      bit c_act = 0, h_act = 0, c_we = 0, h_we = 0, ok, fill = 1;
      logic [ADDR_W-1:0] c_addr = '0, h_addr = '0;
      logic [15:0] c_wd = '0;
      logic [31:0] h_wd = '0;
      int c_age = 0, h_age = 0;
      for (int i = 0; i < 256; i++) begin
         v = $urandom; mem[i] = v; cm[i] = v[15:0];
         v = $urandom; mem[256 + i] = v; hm[i] = v;
      end
      for (int cyc = 0; cyc < 1500; cyc++) begin
         if (cyc == 1200) fill = 0;
         if (!rambus_wb_cyc_o) ack_delay = $urandom_range(1, 4);
         step();
         if (rambus_wb_cyc_o) begin
            if (rambus_wb_sel_o == 4'b0011)
               ok = c_act && rambus_wb_addr_o == c_addr && rambus_wb_we_o == c_we &&
                    (!c_we || rambus_wb_dat_o == {16'h0, c_wd});
            else if (rambus_wb_sel_o == 4'b1111)
               ok = h_act && rambus_wb_addr_o == h_addr && rambus_wb_we_o == h_we &&
                    (!h_we || rambus_wb_dat_o == h_wd);
            else ok = 0;
            checks++;
            if (!ok) begin errors++; $display("FAIL rnd_bus: sel=%b addr=%h we=%b dat=%h core=%b/%h host=%b/%h",
                                              rambus_wb_sel_o, rambus_wb_addr_o, rambus_wb_we_o, rambus_wb_dat_o, c_act, c_addr, h_act, h_addr); end
         end
         if (core_done) begin
            checks++;
            if (!c_act || o_wb_ack || (!c_we && core_rdata !== cm[c_addr[7:0]])) begin
               errors++; $display("FAIL rnd_core_done: active=%b ack=%b rdata=%h want %h", c_act, o_wb_ack, core_rdata, cm[c_addr[7:0]]);
            end
            if (c_we) cm[c_addr[7:0]] = c_wd;
            c_act = 0; core_req = 0;
         end
         if (o_wb_ack) begin
            checks++;
            if (!h_act || (!h_we && o_wb_data !== hm[h_addr[7:0]])) begin
               errors++; $display("FAIL rnd_host_ack: active=%b data=%h want %h", h_act, o_wb_data, hm[h_addr[7:0]]);
            end
            if (h_we) hm[h_addr[7:0]] = h_wd;
            h_act = 0; i_wb_cyc = 0; i_wb_stb = 0;
         end
         if (c_act && ++c_age > 40) begin errors++; checks++; $display("FAIL rnd_core_timeout: age=%0d want <=40", c_age); c_act = 0; core_req = 0; end
         if (h_act && ++h_age > 40) begin errors++; checks++; $display("FAIL rnd_host_timeout: age=%0d want <=40", h_age); h_act = 0; i_wb_cyc = 0; i_wb_stb = 0; end
         if (fill && !c_act && $urandom_range(0, 2) == 0) begin
            c_act = 1; c_age = 0; c_we = $urandom_range(0, 1); c_addr = ADDR_W'($urandom_range(0, 255));
            c_wd = 16'($urandom);
            core_req = 1; core_we = c_we; core_addr = c_addr; core_wdata = c_wd;
         end
         if (fill && !h_act && !o_wb_ack && $urandom_range(0, 2) == 0) begin
            h_act = 1; h_age = 0; h_we = $urandom_range(0, 1); h_addr = ADDR_W'(256 + $urandom_range(0, 255));
            h_wd = $urandom; hb = $urandom; hb[11:2] = h_addr;
            i_wb_cyc = 1; i_wb_stb = 1; i_wb_we = h_we; i_wb_addr = hb; i_wb_data = h_wd;
         end
      end
      checks++;
      if (c_act || h_act) begin errors++; $display("FAIL rnd_drain: core=%b host=%b still pending want 0/0", c_act, h_act); end
      clear_inputs();
      go_idle();
   endtask

   initial begin
      test_reset();
      test_core_read();
      test_host_write();
      test_round_robin();
      test_host_abort();
      test_reset_mid();
      test_timeout();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
